// File: rtl/timer.sv
// timer: free-running 24-hour HH:MM:SS clock driving a 6-digit, time-multiplexed,
// common-anode seven-segment display (active-low segments and digit strobes).
// Optional feature: define TIMER_DP_BLINK_EN to blink the decimal points that
// separate HH.MM.SS (lit on strobe indices 2 and 4 while the seconds are even).

`define NUMBER_0 8'hC0
`define NUMBER_1 8'hF9
`define NUMBER_2 8'hA4
`define NUMBER_3 8'hB0
`define NUMBER_4 8'h99
`define NUMBER_5 8'h92
`define NUMBER_6 8'h82
`define NUMBER_7 8'hF8
`define NUMBER_8 8'h80
`define NUMBER_9 8'h90

module timer #(
    parameter int unsigned CLK_DIV  = 1024,
    parameter int unsigned SCAN_DIV = 32
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] number,
    output logic [5:0] digit_block
);

    // Counter widths; a divider of 1 still needs a 1-bit register that stays at 0.
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [SW-1:0] scan_cnt;
    logic [2:0]    scan_idx;
    logic [5:0]    sec;
    logic [5:0]    min;
    logic [4:0]    hour;
    logic          tick;
    logic          advance;
    logic [3:0]    digit;
    logic [7:0]    seg;

    assign tick    = (presc == PRESC_MAX);
    assign advance = (scan_cnt == SCAN_MAX);

    // One-second prescaler: wraps on the same edge that bumps the time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Time-of-day counters with seconds -> minutes -> hours carry chain.
    // The >= compares make any out-of-range value fall back to 0 on the next tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec  <= '0;
            min  <= '0;
            hour <= '0;
        end else if (tick) begin
            if (sec >= 6'd59) begin
                sec <= '0;
                if (min >= 6'd59) begin
                    min <= '0;
                    if (hour >= 5'd23) begin
                        hour <= '0;
                    end else begin
                        hour <= hour + 5'd1;
                    end
                end else begin
                    min <= min + 6'd1;
                end
            end else begin
                sec <= sec + 6'd1;
            end
        end
    end

    // Digit scan: dwell SCAN_DIV cycles per digit, then rotate the strobe index 0..5.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (advance) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx >= 3'd5) ? 3'd0 : scan_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Select the BCD digit and strobe for the current scan index.
    // Unused index codes still drive a single strobe so the display never goes dark.
    always_comb begin
        digit       = 4'd0;
        digit_block = 6'b111110;
        case (scan_idx)
            3'd0: begin
                digit       = 4'(sec % 6'd10);
                digit_block = 6'b111110;
            end
            3'd1: begin
                digit       = 4'(sec / 6'd10);
                digit_block = 6'b111101;
            end
            3'd2: begin
                digit       = 4'(min % 6'd10);
                digit_block = 6'b111011;
            end
            3'd3: begin
                digit       = 4'(min / 6'd10);
                digit_block = 6'b110111;
            end
            3'd4: begin
                digit       = 4'(hour % 5'd10);
                digit_block = 6'b101111;
            end
            3'd5: begin
                digit       = 4'(hour / 5'd10);
                digit_block = 6'b011111;
            end
            default: begin
                digit       = 4'd0;
                digit_block = 6'b111110;
            end
        endcase
    end

    // Seven-segment decode; dp stays off unless the blink option lights it.
    always_comb begin
        case (digit)
            4'd0:    seg = `NUMBER_0;
            4'd1:    seg = `NUMBER_1;
            4'd2:    seg = `NUMBER_2;
            4'd3:    seg = `NUMBER_3;
            4'd4:    seg = `NUMBER_4;
            4'd5:    seg = `NUMBER_5;
            4'd6:    seg = `NUMBER_6;
            4'd7:    seg = `NUMBER_7;
            4'd8:    seg = `NUMBER_8;
            4'd9:    seg = `NUMBER_9;
            default: seg = `NUMBER_0;
        endcase
        number = seg;
`ifdef TIMER_DP_BLINK_EN
        // Separator dots after the minutes and hours digits, lit on even seconds.
        if ((scan_idx == 3'd2 || scan_idx == 3'd4) && !sec[0]) begin
            number = {1'b0, seg[6:0]};
        end
`endif
    end

endmodule

// File: tb/tb_timer.sv
// tb_timer: self-checking bench for timer. Three instances share one clock:
// dut0 uses default dividers, dut1 runs CLK_DIV=1/SCAN_DIV=1 through a full day,
// dut2 runs CLK_DIV=1/SCAN_DIV=3 for carry checks and a mid-count async reset.
// The reference model derives the display from the number of edges since reset.

module tb_timer;

`ifdef TIMER_DP_BLINK_EN
    localparam bit DpEn = 1'b1;
`else
    localparam bit DpEn = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rst0 = 1'b0;
    logic       rst1 = 1'b0;
    logic       rst2 = 1'b0;
    logic [7:0] nb0, nb1, nb2;
    logic [5:0] db0, db1, db2;

    int n0 = 0;
    int n1 = 0;
    int n2 = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    timer dut0 (.clk(clk), .rst(rst0), .number(nb0), .digit_block(db0));
    timer #(.CLK_DIV(1), .SCAN_DIV(1)) dut1 (.clk(clk), .rst(rst1), .number(nb1),
                                            .digit_block(db1));
    timer #(.CLK_DIV(1), .SCAN_DIV(3)) dut2 (.clk(clk), .rst(rst2), .number(nb2),
                                            .digit_block(db2));

    // Rising edges seen since each instance's reset was last released.
    always @(posedge clk or posedge rst0) if (rst0) n0 <= 0; else n0 <= n0 + 1;
    always @(posedge clk or posedge rst1) if (rst1) n1 <= 0; else n1 <= n1 + 1;
    always @(posedge clk or posedge rst2) if (rst2) n2 <= 0; else n2 <= n2 + 1;

    // Expected display after n edges: elapsed seconds and scan slot by plain division.
    function automatic void model(input int n, input int cdiv, input int sdiv,
                                  output logic [7:0] nb, output logic [5:0] db);
        int t, s, m, h, idx, d;
        t   = (n / cdiv) % 86400;
        h   = t / 3600;
        m   = (t / 60) % 60;
        s   = t % 60;
        idx = (n / sdiv) % 6;
        case (idx)
            0:       d = s % 10;
            1:       d = s / 10;
            2:       d = m % 10;
            3:       d = m / 10;
            4:       d = h % 10;
            default: d = h / 10;
        endcase
        nb = seg_tab[d];
        if (DpEn && (idx == 2 || idx == 4) && (s % 2 == 0)) nb[7] = 1'b0;
        db = 6'b111111;
        db[idx] = 1'b0;
    endfunction

    task automatic test_reset;
        logic [7:0] en;
        logic [5:0] ed;
        #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst2 = 1'b1;
        #1;
        // No clock edge has happened yet: reset alone must set the outputs.
        n_checks++;
        if (db0 !== 6'b111110 || nb0 !== 8'hC0)
            $display("FAIL reset_noclk dut0 got %b/%h want 111110/c0", db0, nb0);
        else n_pass++;
        n_checks++;
        if (db1 !== 6'b111110 || nb1 !== 8'hC0)
            $display("FAIL reset_noclk dut1 got %b/%h want 111110/c0", db1, nb1);
        else n_pass++;
        n_checks++;
        if (db2 !== 6'b111110 || nb2 !== 8'hC0)
            $display("FAIL reset_noclk dut2 got %b/%h want 111110/c0", db2, nb2);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (db0 !== 6'b111110 || nb0 !== 8'hC0)
            $display("FAIL reset_held dut0 got %b/%h want 111110/c0", db0, nb0);
        else n_pass++;
        rst0 = 1'b0;
        rst1 = 1'b0;
        for (int i = 0; i < 100 && n0 < 40; i++) begin
            @(negedge clk);
            model(n0, 1024, 32, en, ed);
            n_checks++;
            if (nb0 !== en || db0 !== ed)
                $display("FAIL reset_run n=%0d got %h/%b want %h/%b", n0, nb0, db0, en, ed);
            else n_pass++;
            if (n0 == 31 || n0 == 32) begin
                n_checks++;
                if (db0 !== ((n0 == 31) ? 6'b111110 : 6'b111101))
                    $display("FAIL first_strobe n=%0d got %b", n0, db0);
                else n_pass++;
            end
        end
        if (n0 < 40) begin
            n_checks++;
            $display("FAIL reset_run timeout n=%0d want 40", n0);
        end
        // Asynchronous pulse between edges while dut0 shows a non-reset strobe.
        #($urandom_range(1, 3));
        rst0 = 1'b1;
        #1;
        n_checks++;
        if (db0 !== 6'b111110 || nb0 !== 8'hC0)
            $display("FAIL reset_async dut0 got %b/%h want 111110/c0", db0, nb0);
        else n_pass++;
        @(negedge clk);
        rst0 = 1'b0;
    endtask

    task automatic test_scan_rotation;
        logic [7:0] en;
        logic [5:0] ed;
        for (int i = 0; i < 400 && n0 < 200; i++) begin
            @(negedge clk);
            model(n0, 1024, 32, en, ed);
            n_checks++;
            if (nb0 !== en || db0 !== ed)
                $display("FAIL scan n=%0d got %h/%b want %h/%b", n0, nb0, db0, en, ed);
            else n_pass++;
            if (n0 == 160) begin
                n_checks++;
                if (db0 !== 6'b011111 || nb0 !== 8'hC0)
                    $display("FAIL scan_idx5 got %b/%h want 011111/c0", db0, nb0);
                else n_pass++;
            end
            if (n0 == 192) begin
                n_checks++;
                if (db0 !== 6'b111110 || nb0 !== 8'hC0)
                    $display("FAIL scan_wrap got %b/%h want 111110/c0", db0, nb0);
                else n_pass++;
            end
        end
        if (n0 < 200) begin
            n_checks++;
            $display("FAIL scan timeout n=%0d want 200", n0);
        end
    endtask

    task automatic test_first_tick;
        logic [7:0] en;
        logic [5:0] ed;
        for (int i = 0; i < 1500 && n0 < 1200; i++) begin
            @(negedge clk);
            model(n0, 1024, 32, en, ed);
            n_checks++;
            if (nb0 !== en || db0 !== ed)
                $display("FAIL tick n=%0d got %h/%b want %h/%b", n0, nb0, db0, en, ed);
            else n_pass++;
            if (n0 == 1023 || n0 == 1160 || n0 == 1190) begin
                en = (n0 == 1160) ? 8'hF9 : 8'hC0;
                ed = (n0 == 1160) ? 6'b111110 : 6'b111101;
                n_checks++;
                if (nb0 !== en || db0 !== ed)
                    $display("FAIL first_tick n=%0d got %h/%b want %h/%b", n0, nb0, db0, en, ed);
                else n_pass++;
            end
        end
        if (n0 < 1200) begin
            n_checks++;
            $display("FAIL tick timeout n=%0d want 1200", n0);
        end
    endtask

    task automatic test_dp_blink;
        logic [7:0] en;
        logic [5:0] ed;
        for (int i = 0; i < 1500 && n0 < 2220; i++) begin
            @(negedge clk);
            model(n0, 1024, 32, en, ed);
            n_checks++;
            if (nb0 !== en || db0 !== ed)
                $display("FAIL dp_run n=%0d got %h/%b want %h/%b", n0, nb0, db0, en, ed);
            else n_pass++;
            // 1230: idx2 odd sec; 2112: idx0 even sec; 2180: idx2 even sec.
            if (n0 == 1230 || n0 == 2112 || n0 == 2180) begin
                n_checks++;
                if (nb0[7] !== ((n0 == 2180) ? ~DpEn : 1'b1))
                    $display("FAIL dp_bit n=%0d got %b want %b", n0, nb0[7],
                             (n0 == 2180) ? ~DpEn : 1'b1);
                else n_pass++;
            end
        end
        if (n0 < 2220) begin
            n_checks++;
            $display("FAIL dp timeout n=%0d want 2220", n0);
        end
    endtask

    task automatic test_carry;
        logic [7:0] en;
        logic [5:0] ed;
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < 300 && n2 < 130; i++) begin
            @(negedge clk);
            model(n2, 1, 3, en, ed);
            n_checks++;
            if (nb2 !== en || db2 !== ed)
                $display("FAIL carry n=%0d got %h/%b want %h/%b", n2, nb2, db2, en, ed);
            else n_pass++;
            if (n2 == 59) begin
                n_checks++;
                if (nb2 !== 8'h92 || db2 !== 6'b111101)
                    $display("FAIL carry_59 got %h/%b want 92/111101", nb2, db2);
                else n_pass++;
            end
            if (n2 == 60) begin
                n_checks++;
                if (nb2 !== (DpEn ? 8'h79 : 8'hF9) || db2 !== 6'b111011)
                    $display("FAIL carry_60 got %h/%b want %h/111011", nb2, db2,
                             DpEn ? 8'h79 : 8'hF9);
                else n_pass++;
            end
        end
        if (n2 < 130) begin
            n_checks++;
            $display("FAIL carry timeout n=%0d want 130", n2);
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] en;
        logic [5:0] ed;
        for (int i = 0; i < 50000 && n2 < 45296; i++) begin
            @(negedge clk);
            model(n2, 1, 3, en, ed);
            n_checks++;
            if (nb2 !== en || db2 !== ed)
                $display("FAIL day_run n=%0d got %h/%b want %h/%b", n2, nb2, db2, en, ed);
            else n_pass++;
        end
        if (n2 != 45296) begin
            n_checks++;
            $display("FAIL async timeout n=%0d want 45296", n2);
        end
        // 12:34:56 with scan index 2 showing the minutes units digit (4).
        n_checks++;
        if (nb2 !== (DpEn ? 8'h19 : 8'h99) || db2 !== 6'b111011)
            $display("FAIL at_123456 got %h/%b want %h/111011", nb2, db2,
                     DpEn ? 8'h19 : 8'h99);
        else n_pass++;
        #($urandom_range(1, 2));
        rst2 = 1'b1;
        #1;
        n_checks++;
        if (nb2 !== 8'hC0 || db2 !== 6'b111110)
            $display("FAIL async_pulse got %h/%b want c0/111110", nb2, db2);
        else n_pass++;
        rst2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (nb2 !== 8'hF9 || db2 !== 6'b111110)
            $display("FAIL async_restart got %h/%b want f9/111110", nb2, db2);
        else n_pass++;
    endtask

    task automatic test_rollover;
        logic [7:0] en;
        logic [5:0] ed;
        for (int i = 0; i < 90000 && n1 < 86410; i++) begin
            @(negedge clk);
            model(n1, 1, 1, en, ed);
            n_checks++;
            if (nb1 !== en || db1 !== ed)
                $display("FAIL rollover n=%0d got %h/%b want %h/%b", n1, nb1, db1, en, ed);
            else n_pass++;
            if (n1 == 86399) begin
                n_checks++;
                if (nb1 !== 8'hA4 || db1 !== 6'b011111)
                    $display("FAIL at_235959 got %h/%b want a4/011111", nb1, db1);
                else n_pass++;
            end
            if (n1 == 86400) begin
                n_checks++;
                if (nb1 !== 8'hC0 || db1 !== 6'b111110)
                    $display("FAIL at_000000 got %h/%b want c0/111110", nb1, db1);
                else n_pass++;
            end
        end
        if (n1 < 86410) begin
            n_checks++;
            $display("FAIL rollover timeout n=%0d want 86410", n1);
        end
        model(n2, 1, 3, en, ed);
        n_checks++;
        if (nb2 !== en || db2 !== ed)
            $display("FAIL after_reset n=%0d got %h/%b want %h/%b", n2, nb2, db2, en, ed);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan_rotation();
        test_first_tick();
        test_dp_blink();
        test_carry();
        test_async_reset();
        test_rollover();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer.md
# timer

Free-running 24-hour clock (HH:MM:SS) driving a 6-digit, time-multiplexed, common-anode seven-segment display. A prescaler derives a one-second tick from `clk`. A scan counter rotates one active-low digit strobe across the six digits. The 8-bit segment pattern for the strobed digit is driven alongside the strobe. The block sits at the board top level between the system clock and the display pins.

## Interface

Parameters:
- `CLK_DIV`, default 1024: `clk` cycles per one-second tick. Set to the board clock frequency for hardware.
- `SCAN_DIV`, default 32: `clk` cycles each digit stays strobed.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `number`, output, 8: segment pattern for the strobed digit, bits {dp,g,f,e,d,c,b,a}, active-low.
- `digit_block`, output, 6: one-hot active-low digit strobe; bit 0 is the rightmost digit.

## Operation

- Time registers:
  - `sec` counts 0–59.
  - `min` counts 0–59.
  - `hour` counts 0–23.
- On a tick, `sec` increments.
  - `sec` 59→0 carries into `min`.
  - `min` 59→0 carries into `hour`.
  - `hour` 23→0 wraps. 23:59:59 is followed by 00:00:00.
- Digit map by strobe index, with active strobe pattern:
  - Index 0: sec%10, strobe 111110.
  - Index 1: sec/10, strobe 111101.
  - Index 2: min%10, strobe 111011.
  - Index 3: min/10, strobe 110111.
  - Index 4: hour%10, strobe 101111.
  - Index 5: hour/10, strobe 011111.
- Exactly one strobe bit is low at all times, including during reset.
- Digit-to-segment encoding (dp off), in hex:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
  - These are exported as macros `NUMBER_0`..`NUMBER_9`.
- Any out-of-range internal value decodes as `NUMBER_0`.
- `number` is decoded combinationally from the registered strobe index and the registered time. It always matches the digit currently strobed.

## Timing

- Reset values:
  - `sec`, `min`, `hour` = 0; prescaler = 0; scan counter = 0; strobe index = 0.
  - `digit_block` = 6'b111110; `number` = 8'hC0.
- Prescaler counts 0..CLK_DIV-1. The edge at which it equals CLK_DIV-1 wraps it to 0 and increments the time in that same edge.
- The first tick after reset release lands on the CLK_DIV-th rising edge.
- Scan counter counts 0..SCAN_DIV-1. The edge at which it equals SCAN_DIV-1 advances the strobe index (5→0 wraps).
- Full scan period is 6·SCAN_DIV cycles.
- Tick and scan advance on the same edge: both take effect together. The newly strobed digit shows the post-increment time.
- `rst` asserted at any point forces all reset values immediately, without waiting for a clock edge. Counting resumes on the first rising edge after deassertion.
- `CLK_DIV` = 1 and `SCAN_DIV` = 1 are legal: a tick or advance occurs on every edge.

## Configuration

- `TIMER_DP_BLINK_EN` defined:
  - The dp segment (bit 7) is driven low (lit) on strobe indices 2 and 4, as the MM and HH separators.
  - This applies only while `sec` is even, giving a 1 Hz blink.
  - All other digits keep dp off.
- Not defined:
  - Bit 7 of `number` is constant 1.
  - No blink logic is synthesized.

## Test plan

- Reset: assert `rst` → `digit_block` = 111110 and `number` = C0, with no clock edge needed. Deassert → the first strobe change occurs at edge 32.
- Scan rotation (defaults): strobe sequence 111110, 111101, 111011, 110111, 101111, 011111, each held 32 cycles, then back to 111110 at cycle 192. Every strobed digit shows C0 before the first tick.
- First tick: after 1024 cycles, strobe index 0 shows F9 and index 1 shows C0.
- Carry/rollover with `CLK_DIV`=1:
  - After 59 ticks, index 1 shows 92 and index 0 shows 90.
  - The 60th tick → index 2 shows F9 and indices 0–1 show C0.
  - After 86400 ticks, all six digits show C0.
- Async reset mid-count: pulse `rst` between clock edges at time 12:34:56 → outputs return to reset values immediately and time restarts from 00:00:00.
- With `TIMER_DP_BLINK_EN`:
  - At an even second, strobe index 2 shows `number` bit 7 = 0.
  - At an odd second, bit 7 = 1.
  - Index 0 always has bit 7 = 1.
